// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with req/ack data-memory port and pipeline stall; define MISALIGN_TRAP_EN to trap misaligned accesses
module mem_stage_lsu #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] z_MEM,
  input  logic [31:0] B_MEM,
  input  logic        mem_rd_MEM,
  input  logic        mem_wr_MEM,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall_MEM,
  output logic [31:0] load_data,
  output logic        lsu_err,
  output logic        misalign_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] TERM = 8'(TIMEOUT_CYC - 1);
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic w_access, w_mis, w_to, w_issue;
  assign w_access = mem_rd_MEM | mem_wr_MEM;
`ifdef MISALIGN_TRAP_EN
  logic r_mis;
  assign w_mis = |z_MEM[1:0];
  assign misalign_err = r_mis;
  // misaligned access flag is raised for the single DONE cycle that follows it
  always_ff @(posedge clk or posedge reset)
    if (reset) r_mis <= 1'b0;
    else       r_mis <= (r_state == IDLE) & w_access & w_mis;
`else
  logic w_unused;
  assign w_mis = 1'b0;
  assign w_unused = ^z_MEM[1:0];
  assign misalign_err = 1'b0;
`endif
  assign w_to    = (r_cnt == TERM);
  assign w_issue = (r_state == IDLE) & w_access & ~w_mis;
  // next state and stall; reset forces the stall low so the pipeline is released at once
  always_comb begin
    stall_MEM = ~reset & ((r_state == BUSY) | ((r_state == IDLE) & w_access));
    w_next    = r_state == IDLE ? (w_access ? (w_mis ? DONE : BUSY) : IDLE) :
                r_state == BUSY ? ((dm_ack | w_to) ? DONE : BUSY) : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  // memory request, timeout counter and load result; ack beats the terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      load_data <= '0;
      lsu_err   <= 1'b0;
      r_cnt     <= '0;
    end else if (w_issue) begin
      dm_req   <= 1'b1;
      dm_we    <= mem_wr_MEM;
      dm_addr  <= {z_MEM[31:2], 2'b00};
      dm_wdata <= B_MEM;
    end else if (r_state == BUSY) begin
      if (dm_ack) begin
        dm_req <= 1'b0;
        r_cnt  <= '0;
        if (!dm_we) load_data <= dm_rdata;
      end else if (w_to) begin
        dm_req    <= 1'b0;
        r_cnt     <= '0;
        lsu_err   <= 1'b1;
        load_data <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
  logic        clk = 0;
  logic        reset;
  logic [31:0] z_MEM, B_MEM, dm_addr, dm_wdata, dm_rdata, load_data;
  logic        mem_rd_MEM, mem_wr_MEM, dm_req, dm_we, dm_ack, stall_MEM, lsu_err, misalign_err;
  int n_chk = 0, n_err = 0;
  int st, rq, rs;
  logic we, mis;
  logic [31:0] ad, wd;
  mem_stage_lsu dut (
    .clk(clk), .reset(reset), .z_MEM(z_MEM), .B_MEM(B_MEM),
    .mem_rd_MEM(mem_rd_MEM), .mem_wr_MEM(mem_wr_MEM),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall_MEM(stall_MEM),
    .load_data(load_data), .lsu_err(lsu_err), .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic rd, input logic wr, input logic [31:0] z, input logic [31:0] b,
                     input int ack_at, input logic [31:0] rdata,
                     output int o_st, output int o_rq, output int o_rs, output logic o_we,
                     output logic [31:0] o_ad, output logic [31:0] o_wd, output logic o_mis);
    int idx;
    logic prev, done;
    o_st = 0; o_rq = 0; o_rs = 0; o_we = 0; o_ad = 0; o_wd = 0; o_mis = 0;
    idx = 0; prev = 0; done = 0;
    @(negedge clk);
    mem_rd_MEM = rd; mem_wr_MEM = wr; z_MEM = z; B_MEM = b; dm_ack = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (!stall_MEM) begin
        o_mis = misalign_err;
        chk("req_low_in_done", {31'd0, dm_req}, 32'd0);
        mem_rd_MEM = 0; mem_wr_MEM = 0; dm_ack = 0;
        done = 1;
      end else begin
        o_st++;
        if (dm_req) begin
          o_rq++; idx++;
          if (!prev) begin o_rs++; o_we = dm_we; o_ad = dm_addr; o_wd = dm_wdata; end
          dm_ack = (idx == ack_at);
          dm_rdata = rdata;
        end else dm_ack = 0;
        prev = dm_req;
        @(negedge clk);
      end
    end
    chk("terminates", {31'd0, done}, 32'd1);
  endtask
  initial begin
    reset = 1; mem_rd_MEM = 0; mem_wr_MEM = 0; z_MEM = 0; B_MEM = 0; dm_ack = 0; dm_rdata = 0;
    #1;
    chk("rst_req", {31'd0, dm_req}, 0);
    chk("rst_we", {31'd0, dm_we}, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_load", load_data, 0);
    chk("rst_err", {31'd0, lsu_err}, 0);
    chk("rst_mis", {31'd0, misalign_err}, 0);
    chk("rst_stall", {31'd0, stall_MEM}, 0);
    @(negedge clk); @(negedge clk); reset = 0;
    run(1, 0, 32'h100, 0, 1, 32'hDEADBEEF, st, rq, rs, we, ad, wd, mis);
    chk("t1_we", {31'd0, we}, 0);
    chk("t1_addr", ad, 32'h100);
    chk("t1_stall", st, 2);
    chk("t1_load", load_data, 32'hDEADBEEF);
    run(0, 1, 32'h204, 32'h12345678, 5, 32'hFFFFFFFF, st, rq, rs, we, ad, wd, mis);
    chk("t2_we", {31'd0, we}, 1);
    chk("t2_addr", ad, 32'h204);
    chk("t2_wdata", wd, 32'h12345678);
    chk("t2_stall", st, 6);
    chk("t2_load", load_data, 32'hDEADBEEF);
    run(1, 1, 32'h300, 32'hCAFEF00D, 1, 32'h0, st, rq, rs, we, ad, wd, mis);
    chk("both_we", {31'd0, we}, 1);
    chk("both_load", load_data, 32'hDEADBEEF);
    run(1, 0, 32'h40, 0, 64, 32'hA5A5A5A5, st, rq, rs, we, ad, wd, mis);
    chk("tc_ack_stall", st, 65);
    chk("tc_ack_err", {31'd0, lsu_err}, 0);
    chk("tc_ack_load", load_data, 32'hA5A5A5A5);
    run(1, 0, 32'h10, 0, 1, 32'h1, st, rq, rs, we, ad, wd, mis);
    chk("b2b0_addr", ad, 32'h10);
    chk("b2b0_rises", rs, 1);
    chk("b2b0_load", load_data, 32'h1);
    run(1, 0, 32'h14, 0, 1, 32'h2, st, rq, rs, we, ad, wd, mis);
    chk("b2b1_addr", ad, 32'h14);
    chk("b2b1_rises", rs, 1);
    chk("b2b1_load", load_data, 32'h2);
`ifdef MISALIGN_TRAP_EN
    run(1, 0, 32'h102, 0, 1, 32'h33333333, st, rq, rs, we, ad, wd, mis);
    chk("mis_req", rq, 0);
    chk("mis_stall", st, 1);
    chk("mis_flag", {31'd0, mis}, 1);
    chk("mis_load", load_data, 32'h2);
    #1 @(negedge clk);
    chk("mis_pulse", {31'd0, misalign_err}, 0);
`else
    run(1, 0, 32'h102, 0, 1, 32'h33333333, st, rq, rs, we, ad, wd, mis);
    chk("unal_addr", ad, 32'h100);
    chk("unal_stall", st, 2);
    chk("unal_flag", {31'd0, mis}, 0);
    chk("unal_load", load_data, 32'h33333333);
`endif
    run(1, 0, 32'h80, 0, 0, 32'h0, st, rq, rs, we, ad, wd, mis);
    chk("to_req_cycles", rq, 64);
    chk("to_stall", st, 65);
    chk("to_err", {31'd0, lsu_err}, 1);
    chk("to_load", load_data, 0);
    run(1, 0, 32'h84, 0, 2, 32'h77, st, rq, rs, we, ad, wd, mis);
    chk("after_to_load", load_data, 32'h77);
    chk("after_to_err", {31'd0, lsu_err}, 1);
    @(negedge clk);
    mem_rd_MEM = 1; z_MEM = 32'h40;
    @(negedge clk); @(negedge clk);
    chk("mid_busy_req", {31'd0, dm_req}, 1);
    reset = 1;
    #1;
    chk("rst_busy_req", {31'd0, dm_req}, 0);
    chk("rst_busy_stall", {31'd0, stall_MEM}, 0);
    mem_rd_MEM = 0;
    @(negedge clk); reset = 0;
    chk("rst_busy_err", {31'd0, lsu_err}, 0);
    run(1, 0, 32'h8, 0, 2, 32'h0BADF00D, st, rq, rs, we, ad, wd, mis);
    chk("t4_addr", ad, 32'h8);
    chk("t4_stall", st, 3);
    chk("t4_load", load_data, 32'h0BADF00D);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
